// File: rtl/hnoc_pkg.sv
// Shared HNoC definitions: flit field defaults, the receive-checker state encoding
// and the saturating arithmetic used by the statistics counters.
package hnoc_pkg;

   localparam int HNOC_SEQ_WIDTH = 8;
   localparam int HNOC_TS_WIDTH  = 16;
   localparam int HNOC_TS_LSB    = 0;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RUN     = 2'd1,
      ST_DONE    = 2'd2,
      ST_TIMEOUT = 2'd3
   } rx_state_t;

   function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
      logic [32:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[32] ? 32'hFFFF_FFFF : s[31:0];
   endfunction

   function automatic logic [15:0] sat_inc16(input logic [15:0] a);
      return (a == 16'hFFFF) ? a : a + 16'd1;
   endfunction

endpackage

// File: rtl/seq_table.sv
// Per-source expected-sequence register file: one combinational read port with
// write-through bypass and one write port driven from the pipeline stage.
module seq_table #(
   parameter int Entries   = 4,
   parameter int AddrWidth = 2,
   parameter int SeqWidth  = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [AddrWidth-1:0] rd_addr,
   output logic [SeqWidth-1:0]  rd_data,
   input  logic                 wr_en,
   input  logic [AddrWidth-1:0] wr_addr,
   input  logic [SeqWidth-1:0]  wr_data
);

   logic [SeqWidth-1:0] mem [Entries];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < Entries; i++) mem[i] <= '0;
      end else if (wr_en && (int'(wr_addr) < Entries)) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // A back-to-back flit from the same source must see the entry being written now.
   always_comb begin
      rd_data = '0;
      if (wr_en && (wr_addr == rd_addr)) rd_data = wr_data;
      else if (int'(rd_addr) < Entries)  rd_data = mem[rd_addr];
   end

endmodule

// File: rtl/pe_rx_checker.sv
// Receive-side PE endpoint: sinks NoC flits under a ready mask, checks routing and
// per-source sequence numbers, gathers latency statistics and flags done/timeout.
module pe_rx_checker
   import hnoc_pkg::*;
#(
   parameter int address       = 0,
   parameter int numPE         = 4,
   parameter int AddressWidth  = $clog2(numPE),
   parameter int DataWidth     = 32,
   parameter int TotalWidth    = DataWidth + AddressWidth,
   parameter int ExpectedPkts  = 100,
   parameter int SeqWidth      = HNOC_SEQ_WIDTH,
   parameter int TsWidth       = HNOC_TS_WIDTH,
   parameter int TimeoutCycles = 1024,
   parameter logic [7:0] ReadyMask = 8'hFF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [TotalWidth-1:0] i_data,
   input  logic                  i_data_valid,
   output logic                  o_data_ready,
   output logic [31:0]           o_rx_count,
   output logic [15:0]           o_route_err,
   output logic [15:0]           o_seq_err,
   output logic [TsWidth-1:0]    o_lat_min,
   output logic [TsWidth-1:0]    o_lat_max,
   output logic [31:0]           o_lat_sum,
   output logic                  o_done,
   output logic                  o_timeout,
   output rx_state_t             o_dbg_state
);

   localparam int IdleWidth = $clog2(TimeoutCycles + 1);

   logic [TsWidth-1:0]      cyc;
   logic                    accept;
   logic [AddressWidth-1:0] in_dst, in_src;
   logic [SeqWidth-1:0]     in_seq, exp_seq_rd;
   logic [TsWidth-1:0]      in_ts;
   logic                    rsvd_unused;

   logic                    p_valid, p_dst_err, p_seq_bad;
   logic [AddressWidth-1:0] p_src;
   logic [SeqWidth-1:0]     p_seq;
   logic [TsWidth-1:0]      p_lat;

   rx_state_t               state;
   logic [IdleWidth-1:0]    idle_cnt;
   logic                    last_pkt, timeout_hit;

   assign in_dst      = i_data[TotalWidth-1:DataWidth];
   assign in_src      = i_data[DataWidth-1 -: AddressWidth];
   assign in_seq      = i_data[TsWidth+SeqWidth-1:TsWidth];
   assign in_ts       = i_data[HNOC_TS_LSB +: TsWidth];
   assign rsvd_unused = ^i_data[DataWidth-AddressWidth-1:TsWidth+SeqWidth];

   // valid/ready: a flit transfers on a rising clk edge where i_data_valid and
   // o_data_ready are both high; while ready is low the sender holds i_data stable.
   assign o_data_ready = ReadyMask[cyc[2:0]] & ~rst;
   assign accept       = i_data_valid & o_data_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) cyc <= '0;
      else     cyc <= cyc + 1'b1;
   end

   seq_table #(
      .Entries  (numPE),
      .AddrWidth(AddressWidth),
      .SeqWidth (SeqWidth)
   ) u_seq_table (
      .clk    (clk),
      .rst    (rst),
      .rd_addr(in_src),
      .rd_data(exp_seq_rd),
      .wr_en  (p_valid),
      .wr_addr(p_src),
      .wr_data(p_seq + SeqWidth'(1))
   );

   // Capture stage: checks and latency are resolved at the acceptance edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         p_valid   <= 1'b0;
         p_dst_err <= 1'b0;
         p_seq_bad <= 1'b0;
         p_src     <= '0;
         p_seq     <= '0;
         p_lat     <= '0;
      end else begin
         p_valid <= accept;
         if (accept) begin
            p_dst_err <= (in_dst != AddressWidth'(address));
            p_seq_bad <= (in_seq != exp_seq_rd);
            p_src     <= in_src;
            p_seq     <= in_seq;
            p_lat     <= cyc - in_ts;
         end
      end
   end

   assign last_pkt    = p_valid && ((o_rx_count + 32'd1) == 32'(ExpectedPkts));
   assign timeout_hit = !accept && (idle_cnt == IdleWidth'(TimeoutCycles - 1));
   assign o_dbg_state = state;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= ST_IDLE;
         idle_cnt    <= '0;
         o_done      <= 1'b0;
         o_timeout   <= 1'b0;
         o_rx_count  <= '0;
         o_route_err <= '0;
         o_seq_err   <= '0;
         o_lat_min   <= '1;
         o_lat_max   <= '0;
         o_lat_sum   <= '0;
      end else begin
         if (accept)              idle_cnt <= '0;
         else if (state == ST_RUN) idle_cnt <= idle_cnt + 1'b1;

         // The final packet takes priority over a coincident watchdog expiry.
         case (state)
            ST_IDLE: if (accept) state <= ST_RUN;
            ST_RUN: begin
               if (last_pkt) begin
                  state  <= ST_DONE;
                  o_done <= 1'b1;
               end else if (timeout_hit) begin
                  state     <= ST_TIMEOUT;
                  o_timeout <= 1'b1;
               end
            end
            default: ;
         endcase

         if (p_valid) begin
            o_rx_count <= o_rx_count + 32'd1;
            // Traffic arriving after DONE is an overflow and is booked as a route error.
            if (p_dst_err || (state == ST_DONE)) o_route_err <= sat_inc16(o_route_err);
            if (p_seq_bad) o_seq_err <= sat_inc16(o_seq_err);
            if (p_lat < o_lat_min) o_lat_min <= p_lat;
            if (p_lat > o_lat_max) o_lat_max <= p_lat;
            o_lat_sum <= sat_add32(o_lat_sum, 32'(p_lat));
         end
      end
   end

endmodule

// File: doc/pe_rx_checker.md
# pe_rx_checker

Synthesizable receive-side endpoint for one HNoC PE port. It sinks packets from the NoC output port (`o_pe_dataN`, `o_pe_data_validN`, `i_pe_data_readyN`) and drives back-pressure through a programmable ready mask. It checks routing and per-source sequence numbers, measures latency against a shared timebase, and raises `o_done` when the expected packet count arrives. It is the counterpart of the `pe` traffic transmitter and replaces the bench-only packet counting with hardware usable on silicon.

## Interface
- `address`, 0: this PE's NoC address.
- `numPE`, 4: number of PEs, which is also the number of sequence-table entries.
- `AddressWidth`, `$clog2(numPE)`: width of the address field.
- `DataWidth`, 32: payload width. Must satisfy DataWidth ≥ AddressWidth+SeqWidth+TsWidth.
- `TotalWidth`, DataWidth+AddressWidth: width of the full flit.
- `ExpectedPkts`, 100: packet count at which `o_done` asserts.
- `SeqWidth`, 8: width of the sequence-number field.
- `TsWidth`, 16: width of the injection-timestamp field.
- `TimeoutCycles`, 1024: maximum idle gap allowed in RUN.
- `ReadyMask`, 8'hFF: back-pressure pattern, indexed by the low 3 bits of the cycle counter.

Ports:
- `clk`  in  1  PE clock (clk100 domain). This is the only clock.
- `rst`  in  1  Asynchronous, active-high reset.
- `i_data`  in  TotalWidth  Flit from the NoC.
- `i_data_valid`  in  1  Flit valid.
- `o_data_ready`  out  1  Sink ready.
- `o_rx_count`  out  32  Packets accepted.
- `o_route_err`  out  16  Flits whose destination does not equal `address`.
- `o_seq_err`  out  16  Sequence mismatches.
- `o_lat_min`  out  TsWidth  Minimum latency seen, in cycles.
- `o_lat_max`  out  TsWidth  Maximum latency seen, in cycles.
- `o_lat_sum`  out  32  Accumulated latency, saturating.
- `o_done`  out  1  Sticky. ExpectedPkts packets have been received.
- `o_timeout`  out  1  Sticky. A watchdog expiry occurred.

## Operation
- Flit fields:
  - Destination: `[TotalWidth-1:DataWidth]`.
  - Source: `[DataWidth-1 -: AddressWidth]`.
  - Sequence: `[TsWidth+SeqWidth-1:TsWidth]`.
  - Timestamp: `[TsWidth-1:0]`.
- Timebase: a free-running TsWidth-bit cycle counter that resets to 0. All PEs leave reset together, so their timebases are aligned.
- Handshake:
  - `o_data_ready = ReadyMask[cyc[2:0]]` while out of reset.
  - A flit is accepted on a clock edge where valid and ready are both high.
  - Flits are never dropped; the sender holds the flit while ready is low.
- On each accepted flit:
  - Destination ≠ `address`: `route_err` +1. Sequence and latency are still processed.
  - Sequence ≠ `exp_seq[src]`: `seq_err` +1.
  - In both sequence cases, set `exp_seq[src]` = seq+1, mod 2^SeqWidth. The table resyncs and never stalls.
  - Latency = (cyc − ts) mod 2^TsWidth.
  - Update `lat_min` and `lat_max`.
  - `lat_sum` += latency, saturating at 2^32−1.
  - `rx_count` +1.
- The error counters saturate at 16'hFFFF.
- FSM:
  - IDLE: the first acceptance moves to RUN.
  - RUN: `rx_count` reaching ExpectedPkts moves to DONE. An idle counter reaching TimeoutCycles moves to TIMEOUT.
  - DONE: terminal. `o_done` stays high. Any further acceptance still counts and also increments `route_err`, marking it as an overflow.
  - TIMEOUT: terminal. `o_timeout` stays high. Statistics continue to update.
- Idle counter: resets on every acceptance and counts only in RUN.

## Timing
- Reset values:
  - `o_data_ready` = 0 while `rst` is high.
  - All counters and `o_lat_max` = 0.
  - `o_lat_min` = all-ones.
  - `o_done` = `o_timeout` = 0.
  - `exp_seq[*]` = 0.
  - State = IDLE.
- Latency is measured as `cyc` at the acceptance edge minus the flit timestamp.
- Pipeline depth is one register stage. A flit accepted at edge N is visible on the stats outputs after edge N+1.
- `o_done` rises at edge N+1 after the ExpectedPkts-th acceptance.
- Back-to-back acceptance every cycle is sustained. No throughput loss is allowed beyond `ReadyMask`.
- If a timeout and the final packet occur in the same cycle, the packet wins: the next state is DONE.
- Asserting `rst` mid-stream returns everything to reset values immediately, asynchronously. A flit in flight is discarded.
- Timestamp wrap-around is handled by the modulo subtraction. Latencies of 2^TsWidth or more alias and are unsupported.

## Structure
- Package `hnoc_pkg` holds:
  - The field-offset localparams, shared with `pe`.
  - The state enum (IDLE, RUN, DONE, TIMEOUT).
  - The saturating-add function.
- Sub-module `seq_table`: numPE × SeqWidth register file.
  - One combinational read port, indexed by src.
  - One write port, written in the pipeline stage.
  - Same-cycle read/write on the same src returns the value being written (bypass).

## Test plan
- ExpectedPkts=4. Send source 1, seq 0..3, ts = cyc−5, one per cycle, ReadyMask=FF. Expect:
  - `rx_count` = 4, `lat_min` = `lat_max` = 5, `lat_sum` = 20.
  - `o_done` high one edge after the 4th acceptance, with 0 errors.
- Send seq 0,1,3,4 from source 2. Expect `seq_err` = 1 and no further errors, showing the table resynced.
- Send a flit with destination = `address`+1. Expect `route_err` = 1 and `rx_count` = 1.
- ReadyMask=8'hAA with valid held high. Expect:
  - Ready alternates.
  - 4 acceptances in 8 cycles.
  - The held flit is accepted exactly once.
- TimeoutCycles=16. Send 1 flit, then idle 16 cycles. Expect `o_timeout` = 1 and `o_done` = 0.
- Assert `rst` after 2 of 4 flits. Expect all outputs back to reset values, and a fresh run starting from seq 0 with no errors.
